// File: rtl/pwm_cmd_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : pwm_cmd_scheduler                                            |
// | Brief    : Queues decoded UART command packets and applies them to the  |
// |            PWM/DAC channel bank one at a time, stopping a channel while |
// |            its configuration is rewritten.                              |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
module pwm_cmd_scheduler #(
    parameter int _NUM_CHANNELS = 3,
    parameter int _PAT_WIDTH    = 32,
    parameter int _FIFO_DEPTH   = 4,
    parameter int _TIMEOUT      = 1000
) (
    input  logic                          clk_50M,
    input  logic                          rst_n,
    input  logic [7:0]                    func_reg,
    input  logic [79:0]                   pkt_data,
    input  logic                          pack_done,
    input  logic [_NUM_CHANNELS-1:0]      ch_busy,
    output logic [_NUM_CHANNELS-1:0]      ch_en,
    output logic                          cfg_wr,
    output logic [7:0]                    cfg_ch,
    output logic [7:0]                    cfg_duty,
    output logic [15:0]                   cfg_dessert,
    output logic [7:0]                    cfg_num,
    output logic [_PAT_WIDTH-1:0]         cfg_pat,
    output logic                          cmd_drop,
    output logic                          cmd_err,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(_FIFO_DEPTH):0]  fifo_level
);

    localparam int                  c_PTR_W     = $clog2(_FIFO_DEPTH);
    localparam int                  c_TO_W      = $clog2(_TIMEOUT + 1);
    localparam logic [c_PTR_W:0]    c_FULL      = _FIFO_DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W:0]    c_PTR_ONE   = 1;
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0]   c_TO_ONE    = 1;
    localparam logic [7:0]          c_FN_CONFIG = 8'h01;
    localparam logic [7:0]          c_FN_ENABLE = 8'h02;
    localparam logic [7:0]          c_FN_ABORT  = 8'h03;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_DECODE    = 3'd1;
    localparam logic [2:0] c_WAIT_IDLE = 3'd2;
    localparam logic [2:0] c_WRITE     = 3'd3;
    localparam logic [2:0] c_RESTORE   = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [87:0]                fifo_mem_q [_FIFO_DEPTH];
    logic [c_PTR_W:0]           wr_ptr_q, rd_ptr_q, level;
    logic [87:0]                cmd_q;
    logic [_NUM_CHANNELS-1:0]   ch_en_q, ch_mask;
    logic                       en_save_q;
    logic [c_TO_W-1:0]          to_cnt_q;
    logic [7:0]                 cfg_ch_q, cfg_duty_q, cfg_num_q, drop_cnt_q;
    logic [15:0]                cfg_dessert_q;
    logic [_PAT_WIDTH-1:0]      cfg_pat_q;
    logic                       cmd_drop_q;

    logic       abort, push_req, full, push, drop, pop;
    logic [7:0] cmd_func, cmd_ch;
    logic       cmd_bad, busy_sel, to_hit;
    logic       unused_cmd_bits;

    // ABORT never enters the queue; everything else is queued and judged at decode
    assign abort    = pack_done && (func_reg == c_FN_ABORT);
    assign push_req = pack_done && (func_reg != c_FN_ABORT);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == c_FULL);
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign pop      = (state_q == c_IDLE) && (level != '0) && !abort;

    assign cmd_func        = cmd_q[87:80];
    assign cmd_ch          = cmd_q[79:72];
    assign unused_cmd_bits = ^cmd_q[71:65];

    for (genvar i = 0; i < _NUM_CHANNELS; i++) begin : g_mask
        assign ch_mask[i] = (cmd_ch == 8'(i));
    end

    assign cmd_bad  = !(|ch_mask) || !((cmd_func == c_FN_CONFIG) || (cmd_func == c_FN_ENABLE));
    assign busy_sel = |(ch_busy & ch_mask);
    assign to_hit   = (to_cnt_q == c_TO_LAST);

    always_ff @(posedge clk_50M) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[c_PTR_W-1:0]] <= {func_reg, pkt_data};
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:      if (level != '0) state_d = c_DECODE;
            c_DECODE:    state_d = (!cmd_bad && cmd_func == c_FN_CONFIG) ? c_WAIT_IDLE : c_IDLE;
            c_WAIT_IDLE: begin
                if (!busy_sel) begin
                    state_d = c_WRITE;
                end else if (to_hit) begin
                    state_d = c_RESTORE;
                end
            end
            c_WRITE:     state_d = c_RESTORE;
            c_RESTORE:   state_d = c_IDLE;
            default:     state_d = c_IDLE;
        endcase
        if (abort) begin
            state_d = c_IDLE;
        end
    end

    always_comb begin
        cfg_wr  = 1'b0;
        cmd_err = 1'b0;
        if (!abort) begin
            cfg_wr  = (state_q == c_WRITE);
            cmd_err = ((state_q == c_DECODE) && cmd_bad) ||
                      ((state_q == c_WAIT_IDLE) && busy_sel && to_hit);
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cmd_q         <= '0;
            ch_en_q       <= '0;
            en_save_q     <= 1'b0;
            to_cnt_q      <= '0;
            cfg_ch_q      <= '0;
            cfg_duty_q    <= '0;
            cfg_dessert_q <= '0;
            cfg_num_q     <= '0;
            cfg_pat_q     <= '0;
            cmd_drop_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            cmd_drop_q <= drop;
            if (drop && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ch_en_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
                    cmd_q    <= fifo_mem_q[rd_ptr_q[c_PTR_W-1:0]];
                end
                case (state_q)
                    c_DECODE: begin
                        if (!cmd_bad && cmd_func == c_FN_ENABLE) begin
                            ch_en_q <= (ch_en_q & ~ch_mask) | (ch_mask & {_NUM_CHANNELS{cmd_q[64]}});
                        end else if (!cmd_bad) begin
                            en_save_q <= |(ch_en_q & ch_mask);
                            ch_en_q   <= ch_en_q & ~ch_mask;
                            to_cnt_q  <= '0;
                        end
                    end
                    c_WAIT_IDLE: begin
                        to_cnt_q <= to_cnt_q + c_TO_ONE;
                        if (!busy_sel) begin
                            cfg_ch_q      <= cmd_ch;
                            cfg_duty_q    <= cmd_q[63:56];
                            cfg_dessert_q <= cmd_q[55:40];
                            cfg_num_q     <= cmd_q[39:32];
                            cfg_pat_q     <= _PAT_WIDTH'(cmd_q[31:0]);
                        end
                    end
                    c_RESTORE: begin
                        ch_en_q <= (ch_en_q & ~ch_mask) | (ch_mask & {_NUM_CHANNELS{en_save_q}});
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ch_en       = ch_en_q;
    assign cfg_ch      = cfg_ch_q;
    assign cfg_duty    = cfg_duty_q;
    assign cfg_dessert = cfg_dessert_q;
    assign cfg_num     = cfg_num_q;
    assign cfg_pat     = cfg_pat_q;
    assign cmd_drop    = cmd_drop_q;
    assign drop_cnt    = drop_cnt_q;
    assign fifo_level  = level;

endmodule
`default_nettype wire
